serial_shifter: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit bus shift unit.
- Accepts an operand, an operation and a shift amount; performs one bit-step per clock; reports result, carry and zero flags.
- Adds logical/arithmetic shifts, rotate-through-carry, a start/busy/done handshake and an optional tri-state bus drive.
- Sits between the accumulator/bus and the ALU result path of the datapath.

---
 rtl/serial_shifter_pkg.sv | 26 ++
 rtl/serial_shifter_if.sv | 42 ++++
 rtl/serial_shifter_shift_step.sv | 34 +++
 rtl/serial_shifter.sv | 96 +++++++++
 tb/tb_serial_shifter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_shifter_pkg.sv
// Shared types for serial_shifter: op codes, FSM states and the direction helper.
// Purely declarative; no logic or latency of its own.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ROL  = 3'b001,
        OP_ROR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_SHR  = 3'b100,
        OP_ASR  = 3'b101,
        OP_RCL  = 3'b110,
        OP_RCR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_left(op_e op);
        return (op == OP_ROL) || (op == OP_SHL) || (op == OP_RCL);
    endfunction

endpackage

// File: rtl/serial_shifter_if.sv
// Request/result bundle for serial_shifter; master issues start, slave returns busy/done/result.
// Optional SERIAL_SHIFTER_TRISTATE_EN adds the oe bus-enable and turns w into a tri net.
interface serial_shifter_if
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) ();

    logic             start;
    op_e              op;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] a;
    logic             cin;
    logic             busy;
    logic             done;
    logic             cf;
    logic             zf;
`ifdef SERIAL_SHIFTER_TRISTATE_EN
    logic             oe;
    tri   [WIDTH-1:0] w;
`else
    logic [WIDTH-1:0] w;
`endif

    modport master (
`ifdef SERIAL_SHIFTER_TRISTATE_EN
        output oe,
`endif
        output start, op, amount, a, cin,
        input  busy, done, w, cf, zf
    );

    modport slave (
`ifdef SERIAL_SHIFTER_TRISTATE_EN
        input  oe,
`endif
        input  start, op, amount, a, cin,
        output busy, done, w, cf, zf
    );

endinterface

// File: rtl/serial_shifter_shift_step.sv
// One combinational bit-step of the shifter datapath: next w and carry from the current ones.
// Zero latency; no flow control.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] w_i,
    input  logic             cf_i,
    output logic [WIDTH-1:0] w_o,
    output logic             cf_o
);

    always_comb begin
        w_o  = w_i;
        cf_o = cf_i;
        case (op_i)
            OP_ROL: w_o = {w_i[WIDTH-2:0], w_i[WIDTH-1]};
            OP_ROR: w_o = {w_i[0], w_i[WIDTH-1:1]};
            OP_SHL: w_o = {w_i[WIDTH-2:0], 1'b0};
            OP_SHR: w_o = {1'b0, w_i[WIDTH-1:1]};
            OP_ASR: w_o = {w_i[WIDTH-1], w_i[WIDTH-1:1]};
            OP_RCL: w_o = {w_i[WIDTH-2:0], cf_i};
            OP_RCR: w_o = {cf_i, w_i[WIDTH-1:1]};
            default: w_o = w_i;
        endcase
        // Every real op ejects the msb when moving left and the lsb when moving right.
        if (op_i != OP_PASS) begin
            cf_o = is_left(op_i) ? w_i[WIDTH-1] : w_i[0];
        end
    end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle shifter: one bit-step per clock, done pulses N+1 cycles after the start edge (1 for N=0).
// start is accepted only in IDLE; SERIAL_SHIFTER_TRISTATE_EN makes w a tri-state bus drive gated by oe.
module serial_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic              clk,
    input logic              rst,
    serial_shifter_if.slave  bus
);

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] w_q;
    logic             cf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] w_d;
    logic             cf_d;
    logic [CNT_W-1:0] amt_d;

    assign amt_d = (bus.op == OP_PASS) ? '0 : bus.amount;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i (op_q),
        .w_i  (w_q),
        .cf_i (cf_q),
        .w_o  (w_d),
        .cf_o (cf_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_PASS;
            w_q     <= '0;
            cf_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // done trails the DONE state by one edge so the pulse lands N+1 cycles after start.
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        w_q   <= bus.a;
                        cf_q  <= bus.cin;
                        op_q  <= bus.op;
                        cnt_q <= amt_d;
                        if (amt_d != '0) begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    w_q   <= w_d;
                    cf_q  <= cf_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.cf   = cf_q;
    assign bus.zf   = (w_q == '0);

`ifdef SERIAL_SHIFTER_TRISTATE_EN
    assign bus.w = bus.oe ? w_q : {WIDTH{1'bz}};
`else
    assign bus.w = w_q;
`endif

endmodule

// File: tb/tb_serial_shifter.sv
// Randomised bench for serial_shifter with an arithmetic reference model and directed literal cases.
module tb_serial_shifter;
    import shifter_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    serial_shifter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    serial_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of N steps computed directly: rotations by modulus, shifts by wide arithmetic.
    function automatic int ref_fn(input int o, input int av, input int n, input int ci);
        int w;
        int c;
        int r;
        int v;
        int sa;
        w = av;
        c = ci;
        if (n != 0) begin
            case (o)
                1: begin r = n % 8; w = ((av << r) | (av >> (8 - r))) & 'hFF; c = w & 1; end
                2: begin r = n % 8; w = ((av >> r) | (av << (8 - r))) & 'hFF; c = (w >> 7) & 1; end
                3: begin w = (av << n) & 'hFF; c = ((av << n) >> 8) & 1; end
                4: begin w = av >> n; c = (av >> (n - 1)) & 1; end
                5: begin
                    sa = (av >= 128) ? av - 256 : av;
                    w  = (sa >>> n) & 'hFF;
                    c  = (sa >>> (n - 1)) & 1;
                end
                6: begin
                    v = (ci << 8) | av; r = n % 9;
                    v = ((v << r) | (v >> (9 - r))) & 'h1FF;
                    w = v & 'hFF; c = v >> 8;
                end
                7: begin
                    v = (ci << 8) | av; r = n % 9;
                    v = ((v >> r) | (v << (9 - r))) & 'h1FF;
                    w = v & 'hFF; c = v >> 8;
                end
                default: begin w = av; c = ci; end
            endcase
        end
        return (c << 8) | w;
    endfunction

    int ref_n;
    int ref_res;
    always @* begin
        ref_n   = (bus.op == OP_PASS) ? 0 : int'(bus.amount);
        ref_res = ref_fn(int'(bus.op), int'(bus.a), ref_n, int'(bus.cin));
    end

    // Model timeline: k counts edges since the accepted start; busy for k<N, done at k=N+1.
    bit m_active  = 1'b0;
    int m_k       = 0;
    int m_n       = 0;
    int exp_w     = 0;
    int exp_cf    = 0;
    bit exp_busy  = 1'b0;
    bit exp_done  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_n      <= 0;
            exp_w    <= 0;
            exp_cf   <= 0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
        end else if (m_active) begin
            m_k      <= m_k + 1;
            exp_busy <= (m_k + 1) < m_n;
            exp_done <= (m_k + 1) == (m_n + 1);
            if ((m_k + 1) == (m_n + 1)) m_active <= 1'b0;
        end else if (bus.start) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_n      <= ref_n;
            exp_w    <= ref_res & 'hFF;
            exp_cf   <= (ref_res >> 8) & 1;
            exp_busy <= ref_n > 0;
            exp_done <= 1'b0;
        end else begin
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'b0, bus.busy}, {31'b0, exp_busy});
        chk("done", {31'b0, bus.done}, {31'b0, exp_done});
        if (!m_active || exp_done) begin
            chk("w",  {24'b0, bus.w}, exp_w);
            chk("cf", {31'b0, bus.cf}, exp_cf);
            chk("zf", {31'b0, bus.zf}, {31'b0, exp_w == 0});
        end
    end

    task automatic run(input int o, input int av, input int am, input int ci, input bit noise,
                       output int lat, output int bcnt);
        bit fin;
        logic [2:0] o3;
        o3 = o[2:0];
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op_e'(o3);
        bus.a      = av[7:0];
        bus.amount = am[CNT_W-1:0];
        bus.cin    = ci[0];
        @(negedge clk);
        bus.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        fin  = 1'b0;
        while (!fin) begin
            if (bus.done) begin
                fin = 1'b1;
            end else if (lat >= 40) begin
                fin = 1'b1;
                checks++;
                failures++;
                $display("FAIL done_timeout: no done after %0d cycles", lat);
            end else begin
                bcnt += int'(bus.busy);
                if (noise) begin
                    bus.start  = ($urandom % 3) == 0;
                    bus.a      = 8'($urandom);
                    bus.op     = op_e'(3'($urandom % 8));
                    bus.amount = CNT_W'($urandom);
                    bus.cin    = 1'($urandom);
                end
                @(negedge clk);
                lat++;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic directed(input string name, input int o, input int av, input int am, input int ci,
                            input bit noise, input int e_lat, input int e_w, input int e_cf);
        int lat;
        int bcnt;
        run(o, av, am, ci, noise, lat, bcnt);
        chk({name, "_lat"},   lat, e_lat);
        chk({name, "_w"},     {24'b0, bus.w}, e_w);
        chk({name, "_cf"},    {31'b0, bus.cf}, e_cf);
        chk({name, "_zf"},    {31'b0, bus.zf}, {31'b0, e_w == 0});
        chk({name, "_model"}, exp_w, e_w);
        if (o == 5) chk({name, "_busycnt"}, bcnt, am);
    endtask

    initial begin
        int lat;
        int bcnt;
        bus.start  = 1'b0;
        bus.op     = OP_PASS;
        bus.a      = '0;
        bus.amount = '0;
        bus.cin    = 1'b0;
`ifdef SERIAL_SHIFTER_TRISTATE_EN
        bus.oe     = 1'b1;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        directed("rol",  1, 'h81, 1, 0, 1'b0, 2, 'h03, 1);
        directed("asr",  5, 'h80, 3, 1, 1'b0, 4, 'hF0, 0);
        directed("rcl9", 6, 'h80, 9, 0, 1'b0, 10, 'h80, 0);
        directed("rcr1", 7, 'h01, 1, 1, 1'b0, 2, 'h80, 1);
        directed("shl8", 3, 'hFF, 8, 0, 1'b0, 9, 'h00, 1);
        directed("pass", 0, 'h5A, 5, 1, 1'b0, 1, 'h5A, 1);
        directed("shr15", 4, 'hFF, 15, 0, 1'b0, 16, 'h00, 0);
        directed("ignore", 2, 'h35, 5, 0, 1'b1, 6, 'hA9, 1);

        for (int i = 0; i < 200; i++) begin
            run(int'($urandom % 8), int'($urandom % 256), int'($urandom % 16),
                int'($urandom % 2), 1'($urandom), lat, bcnt);
        end

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_SHL; bus.a = 8'hFF; bus.amount = 4'd8; bus.cin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_w",    {24'b0, bus.w}, 0);
        chk("rst_cf",   {31'b0, bus.cf}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_done", {31'b0, bus.done}, 0);
        chk("rst_zf",   {31'b0, bus.zf}, 1);
        @(negedge clk);
        rst = 1'b0;
        directed("post_rst", 1, 'h81, 1, 0, 1'b0, 2, 'h03, 1);

`ifdef SERIAL_SHIFTER_TRISTATE_EN
        @(negedge clk);
        bus.oe = 1'b0;
        #1;
        chk("oe_w_z",  {24'b0, bus.w}, {24'b0, 8'bzzzzzzzz});
        chk("oe_cf",   {31'b0, bus.cf}, 1);
        chk("oe_zf",   {31'b0, bus.zf}, 0);
        bus.oe = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
